// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared widths, phase/state encodings and phase-order helper for the draw sequencer
package draw_pkg;

  localparam int X_W             = 10;
  localparam int Y_W             = 9;
  localparam int NREQ_FIXED      = 3;
  localparam int TIMEOUT_DEFAULT = 307200;

  // Phase index doubles as the requester index served by that phase.
  typedef enum logic [1:0] {
    PH_CLEAR = 2'd0,
    PH_SNAKE = 2'd1,
    PH_FOOD  = 2'd2
  } phase_e;

  // Phase states are encoded as phase index + 1 so first_enabled can map directly.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SNAKE = 3'd2;
  localparam logic [2:0] S_FOOD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Lowest enabled phase at or after index lo, or DONE when none remains.
  function automatic logic [2:0] first_enabled(input logic [2:0] mask, input int lo);
    logic [2:0] s;
    s = S_DONE;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) s = 3'(i + 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - per-phase cycle counter that flags when a phase has run TIMEOUT cycles
module phase_watchdog
  import draw_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holds at LAST so a stalled parent cannot wrap the count back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - frame sequencer arbitrating clear/snake/food requesters onto one framebuffer write port
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int NREQ    = NREQ_FIXED
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic [2:0]                phase_en,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ-1:0][X_W-1:0]  req_x,
  input  logic [NREQ-1:0][Y_W-1:0]  req_y,
  input  logic [NREQ-1:0]           req_color,
  output logic [NREQ-1:0]           start,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic                      pixel_color,
  output logic                      pixel_write,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                overrun,
  output logic                      timeout_err
);

  logic [2:0]      state_q, state_d;
  logic [2:0]      mask_q, mask_d;
  logic            pending_q, pending_d;
  logic [7:0]      overrun_q, overrun_d;
  logic            terr_q, terr_d;
  logic [NREQ-1:0] start_q, start_d;
  logic            pw_q, pw_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            color_q, color_d;

  phase_e cur_idx;
  logic   in_phase;
  logic   accept;
  logic   finish;
  logic   expired;
  logic   wd_clr;

  assign in_phase = (state_q == S_CLEAR) || (state_q == S_SNAKE) || (state_q == S_FOOD);

  always_comb begin
    cur_idx = PH_CLEAR;
    case (state_q)
      S_SNAKE: cur_idx = PH_SNAKE;
      S_FOOD:  cur_idx = PH_FOOD;
      default: cur_idx = PH_CLEAR;
    endcase
  end

  assign accept = in_phase && req_valid[cur_idx];
  assign finish = accept && req_last[cur_idx];

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    terr_d    = terr_q;
    pw_d      = accept;
    x_d       = x_q;
    y_d       = y_q;
    color_d   = color_q;

    if (accept) begin
      x_d     = req_x[cur_idx];
      y_d     = req_y[cur_idx];
      color_d = req_color[cur_idx];
    end

    case (state_q)
      S_IDLE: begin
        // A tick landing together with a pending request still makes one frame.
        if (frame_tick || pending_q) begin
          mask_d    = phase_en;
          pending_d = 1'b0;
          state_d   = first_enabled(phase_en, 0);
        end
      end
      S_CLEAR, S_SNAKE, S_FOOD: begin
        if (finish || expired) begin
          state_d = first_enabled(mask_q, int'(cur_idx) + 1);
        end
        if (expired && !finish) terr_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (frame_tick && (state_q != S_IDLE)) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (overrun_q != 8'hFF) begin
        overrun_d = overrun_q + 8'd1;
      end
    end
  end

  // Start is registered so it lands on the first cycle the new phase is occupied.
  always_comb begin
    start_d = '0;
    if (state_d != state_q) begin
      case (state_d)
        S_CLEAR: start_d[PH_CLEAR] = 1'b1;
        S_SNAKE: start_d[PH_SNAKE] = 1'b1;
        S_FOOD:  start_d[PH_FOOD]  = 1'b1;
        default: start_d = '0;
      endcase
    end
  end

  assign wd_clr = !in_phase || (state_d != state_q);

  phase_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= '0;
      terr_q    <= 1'b0;
      start_q   <= '0;
      pw_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      terr_q    <= terr_d;
      start_q   <= start_d;
      pw_q      <= pw_d;
      x_q       <= x_d;
      y_q       <= y_d;
      color_q   <= color_d;
    end
  end

  assign start       = start_q;
  assign pixel_write = pw_q;
  assign x           = x_q;
  assign y           = y_q;
  assign pixel_color = color_q;
  assign busy        = in_phase;
  assign frame_done  = (state_q == S_DONE);
  assign overrun     = overrun_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - directed table-driven bench for draw_sequencer with TIMEOUT=16
module tb_draw_sequencer;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_tick;
  logic [2:0]       phase_en;
  logic [2:0]       req_valid;
  logic [2:0]       req_last;
  logic [2:0][9:0]  req_x;
  logic [2:0][8:0]  req_y;
  logic [2:0]       req_color;
  logic [2:0]       start;
  logic [9:0]       x;
  logic [8:0]       y;
  logic             pixel_color;
  logic             pixel_write;
  logic             busy;
  logic             frame_done;
  logic [7:0]       overrun;
  logic             timeout_err;

  always #5 clk = ~clk;

  draw_sequencer #(.TIMEOUT(16), .NREQ(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .phase_en    (phase_en),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .start       (start),
    .x           (x),
    .y           (y),
    .pixel_color (pixel_color),
    .pixel_write (pixel_write),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       c;
  } pix_t;

  typedef struct {
    logic [2:0] mask;
    int np0, np1, np2;
    bit noise;
    int st0, st1, st2;
    int done_cyc;
    int writes;
    int busy_cycles;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  pix_t expq[$];
  int   st_first[3], st_last[3], st_cnt[3];
  int   dn_first, dn_last, dn_cnt, wr_cnt, busy_cnt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pix_t pix_of(input int i, input int k);
    pix_t p;
    p.x = 10'(100 * i + 7 * k + 1);
    p.y = 9'(50 * i + 3 * k + 2);
    p.c = ((i + k) % 2) == 1;
    return p;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_pw"}, int'(pixel_write), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_color"}, int'(pixel_color), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(frame_done), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_terr"}, int'(timeout_err), 0);
  endtask

  // Requesters answer one cycle after their start pulse with np pixels, last on the final one.
  task automatic run_frame(input logic [2:0] mask, input int np0, input int np1, input int np2,
                           input bit noise1, input int tka, input int tkb, input int ncyc);
    int npix[3];
    int rem[3];
    int kk[3];
    bit go[3];
    pix_t p;
    pix_t e;
    npix[0] = np0; npix[1] = np1; npix[2] = np2;
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; kk[i] = 0; go[i] = 0;
      st_first[i] = -1; st_last[i] = -1; st_cnt[i] = 0;
    end
    dn_first = -1; dn_last = -1; dn_cnt = 0; wr_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    phase_en   = mask;
    frame_tick = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      frame_tick = (cyc == tka) || (cyc == tkb);
      for (int i = 0; i < 3; i++) begin
        if (start[i]) begin
          if (st_first[i] < 0) st_first[i] = cyc;
          st_last[i] = cyc;
          st_cnt[i]++;
        end
      end
      if (frame_done) begin
        if (dn_first < 0) dn_first = cyc;
        dn_last = cyc;
        dn_cnt++;
      end
      if (busy) busy_cnt++;
      if (pixel_write) begin
        wr_cnt++;
        if (expq.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("wr_x", int'(x), int'(e.x));
          chk("wr_y", int'(y), int'(e.y));
          chk("wr_color", int'(pixel_color), int'(e.c));
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (go[i]) begin
          rem[i] = npix[i];
          kk[i]  = 0;
          go[i]  = 0;
        end
        if (rem[i] > 0) begin
          p = pix_of(i, kk[i]);
          req_valid[i] = 1'b1;
          req_last[i]  = (rem[i] == 1);
          req_x[i]     = p.x;
          req_y[i]     = p.y;
          req_color[i] = p.c;
          kk[i]++;
          rem[i]--;
        end else if (i == 1 && noise1) begin
          req_valid[i] = 1'b1;
          req_last[i]  = 1'b1;
          req_x[i]     = 10'd1023;
          req_y[i]     = 9'd511;
          req_color[i] = 1'b1;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
        if (start[i]) go[i] = 1;
      end
    end
    req_valid  = '0;
    req_last   = '0;
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t tbl[5];
    int   n_wr, n_dn, n_st;

    tbl[0] = '{3'b111, 4, 2, 3, 1'b0,  1,  6,  9, 13, 9, 12};
    tbl[1] = '{3'b101, 4, 2, 3, 1'b1,  1, -1,  6, 10, 7,  9};
    tbl[2] = '{3'b000, 4, 2, 3, 1'b0, -1, -1, -1,  1, 0,  0};
    tbl[3] = '{3'b010, 5, 1, 5, 1'b0, -1,  1, -1,  3, 1,  2};
    tbl[4] = '{3'b100, 1, 1, 2, 1'b0, -1, -1,  1,  4, 2,  3};

    reset      = 1'b1;
    frame_tick = 1'b0;
    phase_en   = '0;
    req_valid  = '0;
    req_last   = '0;
    req_x      = '0;
    req_y      = '0;
    req_color  = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_hold");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_rel");

    for (int v = 0; v < 5; v++) begin
      expq.delete();
      if (tbl[v].mask[0]) for (int k = 0; k < tbl[v].np0; k++) expq.push_back(pix_of(0, k));
      if (tbl[v].mask[1]) for (int k = 0; k < tbl[v].np1; k++) expq.push_back(pix_of(1, k));
      if (tbl[v].mask[2]) for (int k = 0; k < tbl[v].np2; k++) expq.push_back(pix_of(2, k));
      run_frame(tbl[v].mask, tbl[v].np0, tbl[v].np1, tbl[v].np2, tbl[v].noise, -1, -1, 20);
      if (tbl[v].st0 < 0) chk($sformatf("v%0d_st0_cnt", v), st_cnt[0], 0);
      else begin
        chk($sformatf("v%0d_st0_cyc", v), st_first[0], tbl[v].st0);
        chk($sformatf("v%0d_st0_cnt", v), st_cnt[0], 1);
      end
      if (tbl[v].st1 < 0) chk($sformatf("v%0d_st1_cnt", v), st_cnt[1], 0);
      else begin
        chk($sformatf("v%0d_st1_cyc", v), st_first[1], tbl[v].st1);
        chk($sformatf("v%0d_st1_cnt", v), st_cnt[1], 1);
      end
      if (tbl[v].st2 < 0) chk($sformatf("v%0d_st2_cnt", v), st_cnt[2], 0);
      else begin
        chk($sformatf("v%0d_st2_cyc", v), st_first[2], tbl[v].st2);
        chk($sformatf("v%0d_st2_cnt", v), st_cnt[2], 1);
      end
      chk($sformatf("v%0d_done_cyc", v), dn_first, tbl[v].done_cyc);
      chk($sformatf("v%0d_done_cnt", v), dn_cnt, 1);
      chk($sformatf("v%0d_writes", v), wr_cnt, tbl[v].writes);
      chk($sformatf("v%0d_busy_cycles", v), busy_cnt, tbl[v].busy_cycles);
      chk($sformatf("v%0d_left_over", v), expq.size(), 0);
      chk($sformatf("v%0d_overrun", v), int'(overrun), 0);
    end

    // Ticks during SNAKE and FOOD: one becomes pending, the other is an overrun.
    expq.delete();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) expq.push_back(pix_of(0, k));
      for (int k = 0; k < 2; k++) expq.push_back(pix_of(1, k));
      for (int k = 0; k < 3; k++) expq.push_back(pix_of(2, k));
    end
    run_frame(3'b111, 4, 2, 3, 1'b0, 7, 10, 32);
    chk("pend_overrun", int'(overrun), 1);
    chk("pend_st0_first", st_first[0], 1);
    chk("pend_st0_second", st_last[0], 15);
    chk("pend_st0_cnt", st_cnt[0], 2);
    chk("pend_done_first", dn_first, 13);
    chk("pend_done_second", dn_last, 27);
    chk("pend_done_cnt", dn_cnt, 2);
    chk("pend_writes", wr_cnt, 18);
    chk("pend_left_over", expq.size(), 0);

    // Clear never finishes: abort after 16 phase cycles, pixel in the abort cycle still lands.
    n_wr = 0; n_dn = 0;
    @(negedge clk);
    phase_en   = 3'b011;
    frame_tick = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (pixel_write) n_wr++;
      if (frame_done) n_dn++;
      if (cyc == 1) chk("to_start_clear", int'(start), 1);
      if (cyc == 16) begin
        chk("to_err_before", int'(timeout_err), 0);
        chk("to_busy_last", int'(busy), 1);
        chk("to_no_start", int'(start), 0);
      end
      if (cyc == 17) begin
        chk("to_start_snake", int'(start), 2);
        chk("to_err_set", int'(timeout_err), 1);
        chk("to_last_pw", int'(pixel_write), 1);
        chk("to_last_x", int'(x), 555);
        chk("to_last_y", int'(y), 77);
      end
      if (cyc == 19) begin
        chk("to_done", int'(frame_done), 1);
        chk("to_snake_x", int'(x), 9);
      end
      req_valid = '0;
      req_last  = '0;
      if (cyc == 16) begin
        req_valid[0] = 1'b1; req_x[0] = 10'd555; req_y[0] = 9'd77; req_color[0] = 1'b1;
      end
      if (cyc == 18) begin
        req_valid[1] = 1'b1; req_last[1] = 1'b1; req_x[1] = 10'd9; req_y[1] = 9'd8; req_color[1] = 1'b0;
      end
    end
    chk("to_writes", n_wr, 2);
    chk("to_done_cnt", n_dn, 1);
    chk("to_err_sticky", int'(timeout_err), 1);

    // Reset in the middle of CLEAR with the requester still streaming.
    n_wr = 0; n_dn = 0; n_st = 0;
    @(negedge clk);
    phase_en   = 3'b111;
    frame_tick = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (cyc == 3) chk("rst_mid_pre_pw", int'(pixel_write), 1);
      if (cyc == 4) chk_reset_outputs("rst_mid");
      if (cyc >= 5) begin
        if (pixel_write) n_wr++;
        if (frame_done) n_dn++;
        if (start != 3'b000) n_st++;
      end
      req_valid[0] = 1'b1;
      req_last[0]  = 1'b0;
      req_x[0]     = 10'd3;
      req_y[0]     = 9'd4;
      req_color[0] = 1'b1;
      reset        = (cyc == 3);
    end
    req_valid = '0;
    chk("rst_after_writes", n_wr, 0);
    chk("rst_after_done", n_dn, 0);
    chk("rst_after_start", n_st, 0);

    // Tick every cycle with silent requesters: overrun counts up, then saturates.
    @(negedge clk);
    phase_en   = 3'b111;
    frame_tick = 1'b1;
    for (int cyc = 1; cyc <= 320; cyc++) begin
      @(negedge clk);
      if (cyc == 40) chk("sat_mid", int'(overrun), 38);
    end
    chk("sat_final", int'(overrun), 255);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
